// File: rtl/mm_region_decoder_pkg.sv
// Shared types and response fill patterns for the memory-mapped region decoder.
package mm_region_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

  localparam logic [31:0] UNMAPPED_PATTERN = 32'h5555_AAAA;
  localparam logic [31:0] TIMEOUT_PATTERN  = 32'hDEAD_BEEF;

endpackage

// File: rtl/mm_region_decoder.sv
// MM request fan-out to NUM_REGIONS regions with a single outstanding read.
// Optional read timeout enabled by defining MM_REGION_DECODER_TIMEOUT_EN.
module mm_region_decoder
  import mm_region_decoder_pkg::*;
#(
  parameter int NUM_REGIONS   = 12,
  parameter int ADDR_W        = 14,
  parameter int REGION_ADDR_W = 10,
  parameter int DATA_W        = 64,
  parameter int RD_TIMEOUT    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iMM_WR_EN,
  input  logic                          iMM_RD_EN,
  input  logic [ADDR_W-1:0]             iMM_ADDR,
  input  logic [DATA_W-1:0]             iMM_WR_DATA,
  output logic [DATA_W-1:0]             oMM_RD_DATA,
  output logic                          oMM_RD_DATA_V,
  output logic                          oMM_BUSY,
  output logic [15:0]                   oDROP_CNT,
  output logic [ADDR_W-1:0]             REG_ADDR,
  output logic [DATA_W-1:0]             REG_WR_DATA,
  output logic [NUM_REGIONS-1:0]        REG_WR_EN,
  output logic [NUM_REGIONS-1:0]        REG_RD_EN,
  input  logic [NUM_REGIONS*DATA_W-1:0] REG_RD_DATA,
  input  logic [NUM_REGIONS-1:0]        REG_RD_DATA_V
);

  localparam int IDX_W = ADDR_W - REGION_ADDR_W;

  if (NUM_REGIONS < 1 || NUM_REGIONS > 16 || DATA_W < 64 || RD_TIMEOUT < 2) begin : g_param_check
    $error("mm_region_decoder: parameter out of range");
  end

  function automatic logic [DATA_W-1:0] fill(input logic [31:0] pat, input logic [ADDR_W-1:0] a);
    fill = '0;
    fill[DATA_W-1 -: 32] = pat;
    fill[ADDR_W-1:0]     = a;
  endfunction

  state_t                  state, next;
  logic                    s1_wr, s1_rd;
  logic [ADDR_W-1:0]       s1_addr;
  logic [DATA_W-1:0]       s1_data;
  logic [IDX_W-1:0]        s1_idx, lat_idx, sel_idx;
  logic                    s1_mapped, sel_v, load;
  logic [DATA_W-1:0]       sel_data, load_val, rd_data;
  logic [NUM_REGIONS-1:0]  wr_hit, rd_hit;
  logic [15:0]             drop_cnt;
`ifdef MM_REGION_DECODER_TIMEOUT_EN
  localparam int TMR_W = $clog2(RD_TIMEOUT);
  logic [TMR_W-1:0]        timer;
  logic [ADDR_W-1:0]       lat_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_wr   <= 1'b0;
      s1_rd   <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_wr   <= iMM_WR_EN;
      s1_rd   <= iMM_RD_EN;
      s1_addr <= iMM_ADDR;
      s1_data <= iMM_WR_DATA;
    end
  end

  assign s1_idx      = s1_addr[ADDR_W-1:REGION_ADDR_W];
  assign REG_ADDR    = s1_addr;
  assign REG_WR_DATA = s1_data;

  // In IDLE the return mux follows stage 1 so a same-cycle return is caught.
  assign sel_idx = (state == ST_IDLE) ? s1_idx : lat_idx;

  always_comb begin
    wr_hit    = '0;
    rd_hit    = '0;
    s1_mapped = 1'b0;
    sel_v     = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (s1_idx == IDX_W'(i)) begin
        s1_mapped = 1'b1;
        wr_hit[i] = s1_wr;
        rd_hit[i] = s1_rd;
      end
      if (sel_idx == IDX_W'(i)) begin
        sel_v    = REG_RD_DATA_V[i];
        sel_data = REG_RD_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next     = state;
    load     = 1'b0;
    load_val = sel_data;
    case (state)
      ST_IDLE: begin
        if (s1_rd) begin
          if (!s1_mapped) begin
            next     = ST_RESP;
            load     = 1'b1;
            load_val = fill(UNMAPPED_PATTERN, s1_addr);
          end else if (sel_v) begin
            next = ST_RESP;
            load = 1'b1;
          end else begin
            next = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (sel_v) begin
          next = ST_RESP;
          load = 1'b1;
        end
`ifdef MM_REGION_DECODER_TIMEOUT_EN
        else if (timer == TMR_W'(RD_TIMEOUT - 1)) begin
          next     = ST_RESP;
          load     = 1'b1;
          load_val = fill(TIMEOUT_PATTERN, lat_addr);
        end
`endif
      end
      ST_RESP: next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  always_comb begin
    REG_WR_EN     = wr_hit;
    REG_RD_EN     = (state == ST_IDLE) ? rd_hit : '0;
    oMM_RD_DATA_V = (state == ST_RESP);
    oMM_BUSY      = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      drop_cnt <= '0;
      lat_idx  <= '0;
`ifdef MM_REGION_DECODER_TIMEOUT_EN
      timer    <= '0;
      lat_addr <= '0;
`endif
    end else begin
      if (load) rd_data <= load_val;
      if (state == ST_IDLE && s1_rd) begin
        lat_idx  <= s1_idx;
`ifdef MM_REGION_DECODER_TIMEOUT_EN
        timer    <= '0;
        lat_addr <= s1_addr;
      end else if (state == ST_WAIT_RD) begin
        timer    <= timer + 1'b1;
`endif
      end
      if (s1_rd && state != ST_IDLE && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign oMM_RD_DATA = rd_data;
  assign oDROP_CNT   = drop_cnt;

endmodule

// File: tb/tb_mm_region_decoder.sv
// Directed bench for mm_region_decoder with a response scoreboard.
module tb_mm_region_decoder;
  localparam int NR = 12;
  localparam int AW = 14;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             iMM_WR_EN, iMM_RD_EN;
  logic [AW-1:0]    iMM_ADDR;
  logic [DW-1:0]    iMM_WR_DATA;
  logic [DW-1:0]    oMM_RD_DATA;
  logic             oMM_RD_DATA_V, oMM_BUSY;
  logic [15:0]      oDROP_CNT;
  logic [AW-1:0]    REG_ADDR;
  logic [DW-1:0]    REG_WR_DATA;
  logic [NR-1:0]    REG_WR_EN, REG_RD_EN;
  logic [NR*DW-1:0] REG_RD_DATA;
  logic [NR-1:0]    REG_RD_DATA_V;

  int total = 0;
  int bad = 0;
  int rd_en_pulses = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  mm_region_decoder #(
    .NUM_REGIONS(NR), .ADDR_W(AW), .REGION_ADDR_W(10), .DATA_W(DW), .RD_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst),
    .iMM_WR_EN(iMM_WR_EN), .iMM_RD_EN(iMM_RD_EN), .iMM_ADDR(iMM_ADDR), .iMM_WR_DATA(iMM_WR_DATA),
    .oMM_RD_DATA(oMM_RD_DATA), .oMM_RD_DATA_V(oMM_RD_DATA_V), .oMM_BUSY(oMM_BUSY), .oDROP_CNT(oDROP_CNT),
    .REG_ADDR(REG_ADDR), .REG_WR_DATA(REG_WR_DATA), .REG_WR_EN(REG_WR_EN), .REG_RD_EN(REG_RD_EN),
    .REG_RD_DATA(REG_RD_DATA), .REG_RD_DATA_V(REG_RD_DATA_V)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then sample; any response is checked against the scoreboard.
  task automatic tick();
    logic [63:0] exp;
    @(posedge clk);
    #1;
    if (REG_RD_EN != '0) rd_en_pulses++;
    if (oMM_RD_DATA_V === 1'b1) begin
      chk("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("resp_data", oMM_RD_DATA, exp);
      end
    end
  endtask

  task automatic idle_in();
    iMM_WR_EN = 1'b0;
    iMM_RD_EN = 1'b0;
  endtask

  task automatic mm_rd(input logic [AW-1:0] a);
    iMM_RD_EN = 1'b1;
    iMM_ADDR  = a;
  endtask

  task automatic region_ret(input int r, input logic [63:0] d);
    REG_RD_DATA_V          = '0;
    REG_RD_DATA_V[r]       = 1'b1;
    REG_RD_DATA[r*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    iMM_ADDR = '0;
    iMM_WR_DATA = '0;
    REG_RD_DATA = '0;
    REG_RD_DATA_V = '0;
    tick();
    tick();
    chk("rst_busy", 64'(oMM_BUSY), 64'd0);
    chk("rst_rdv", 64'(oMM_RD_DATA_V), 64'd0);
    chk("rst_drop", 64'(oDROP_CNT), 64'd0);
    chk("rst_rddata", oMM_RD_DATA, 64'd0);
    chk("rst_wren", 64'(REG_WR_EN), 64'd0);
    chk("rst_rden", 64'(REG_RD_EN), 64'd0);
    rst = 1'b0;
    tick();

    // Write to region 3
    iMM_WR_EN = 1'b1; iMM_ADDR = 14'h0C05; iMM_WR_DATA = 64'h1234;
    tick();
    idle_in();
    chk("wr_en", 64'(REG_WR_EN), 64'h008);
    chk("wr_addr", 64'(REG_ADDR), 64'h0C05);
    chk("wr_data", REG_WR_DATA, 64'h1234);
    tick();
    chk("wr_en_once", 64'(REG_WR_EN), 64'd0);

    // Write to unmapped index 15 is discarded
    iMM_WR_EN = 1'b1; iMM_ADDR = 14'h3C00;
    tick();
    idle_in();
    chk("wr_unmapped", 64'(REG_WR_EN), 64'd0);
    tick();

    // Read region 8, return at T+4
    mm_rd(14'h2010); sb.push_back(64'hABCD);
    tick();
    idle_in();
    chk("rd8_en", 64'(REG_RD_EN), 64'h100);
    chk("rd8_busy_t1", 64'(oMM_BUSY), 64'd0);
    tick();
    chk("rd8_busy_t2", 64'(oMM_BUSY), 64'd1);
    tick();
    chk("rd8_busy_t3", 64'(oMM_BUSY), 64'd1);
    tick();
    chk("rd8_busy_t4", 64'(oMM_BUSY), 64'd1);
    region_ret(8, 64'hABCD);
    tick();
    REG_RD_DATA_V = '0;
    chk("rd8_v_t5", 64'(oMM_RD_DATA_V), 64'd1);
    chk("rd8_busy_t5", 64'(oMM_BUSY), 64'd1);
    tick();
    chk("rd8_busy_t6", 64'(oMM_BUSY), 64'd0);
    chk("rd8_v_t6", 64'(oMM_RD_DATA_V), 64'd0);

    // Unmapped read answers with the fill pattern at T+2
    mm_rd(14'h3001); sb.push_back(64'h5555_AAAA_0000_3001);
    rd_en_pulses = 0;
    tick();
    idle_in();
    chk("unm_rden", 64'(REG_RD_EN), 64'd0);
    tick();
    chk("unm_v_t2", 64'(oMM_RD_DATA_V), 64'd1);
    tick();
    chk("unm_no_rden", 64'(rd_en_pulses), 64'd0);

    // Simultaneous read+write to region 4 with a same-cycle return
    iMM_WR_EN = 1'b1; iMM_WR_DATA = 64'h77; mm_rd(14'h1000); sb.push_back(64'h4444);
    tick();
    idle_in();
    chk("rw_wren", 64'(REG_WR_EN), 64'h010);
    chk("rw_rden", 64'(REG_RD_EN), 64'h010);
    region_ret(4, 64'h4444);
    tick();
    REG_RD_DATA_V = '0;
    chk("rw_v_t2", 64'(oMM_RD_DATA_V), 64'd1);
    tick();
    chk("rw_hold", oMM_RD_DATA, 64'h4444);
    chk("rw_busy_t3", 64'(oMM_BUSY), 64'd0);

    // Three reads while busy on region 2, stray return from region 5
    mm_rd(14'h0800); sb.push_back(64'h22);
    rd_en_pulses = 0;
    tick();
    chk("drp_rden", 64'(REG_RD_EN), 64'h004);
    mm_rd(14'h0800);
    tick();
    region_ret(5, 64'h55);
    tick();
    REG_RD_DATA_V = '0;
    tick();
    idle_in();
    chk("drp_stray_v", 64'(oMM_RD_DATA_V), 64'd0);
    chk("drp_busy", 64'(oMM_BUSY), 64'd1);
    tick();
    chk("drp_cnt", 64'(oDROP_CNT), 64'd3);
    region_ret(2, 64'h22);
    tick();
    REG_RD_DATA_V = '0;
    chk("drp_v", 64'(oMM_RD_DATA_V), 64'd1);
    tick();
    chk("drp_pulses", 64'(rd_en_pulses), 64'd1);
    chk("drp_cnt_hold", 64'(oDROP_CNT), 64'd3);

`ifdef MM_REGION_DECODER_TIMEOUT_EN
    // No return from region 0: timeout response after 32 wait cycles
    mm_rd(14'h0000); sb.push_back(64'hDEAD_BEEF_0000_0000);
    tick();
    idle_in();
    for (int k = 2; k <= 33; k++) begin
      tick();
      chk("to_wait_v", 64'(oMM_RD_DATA_V), 64'd0);
    end
    tick();
    chk("to_v", 64'(oMM_RD_DATA_V), 64'd1);
    tick();
    chk("to_busy_after", 64'(oMM_BUSY), 64'd0);
`else
    // No return from region 0: read stays outstanding
    mm_rd(14'h0000);
    tick();
    idle_in();
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("hang_busy", 64'(oMM_BUSY), 64'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    // Reset during WAIT_RD abandons the read; late return is ignored
    mm_rd(14'h1800);
    tick();
    idle_in();
    tick();
    chk("rst_wait_busy", 64'(oMM_BUSY), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait_busy0", 64'(oMM_BUSY), 64'd0);
    tick();
    region_ret(6, 64'h66);
    tick();
    REG_RD_DATA_V = '0;
    chk("late_v", 64'(oMM_RD_DATA_V), 64'd0);
    tick();
    chk("late_v2", 64'(oMM_RD_DATA_V), 64'd0);
    chk("late_busy", 64'(oMM_BUSY), 64'd0);
    chk("late_drop", 64'(oDROP_CNT), 64'd0);
    chk("late_rddata", oMM_RD_DATA, 64'd0);
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
